// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access-size codes, FSM states and the
// alignment rule applied to every request.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE
  } lsu_state_e;

  // The illegal size code is handled exactly like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE:         return 1'b0;
      SZ_HALF:         return offset[0];
      SZ_WORD, SZ_ILL: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-granular data-memory bus between the load/store unit (master) and Data_Memory (slave).
interface load_store_unit_if;
  logic [31:0] mem_addr_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: load extract with sign/zero extension and sub-word store merge
// into an existing little-endian memory word.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] mask;
  logic [31:0] lane;

  assign shamt = {offset, 3'b000};

  always_comb begin
    lane_b    = 8'(word >> shamt);
    lane_h    = 16'(word >> shamt);
    load_data = word;
    mask      = '1;
    lane      = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
        mask      = 32'h0000_00FF << shamt;
        lane      = {24'd0, wdata[7:0]} << shamt;
      end
      SZ_HALF: begin
        load_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
        mask      = 32'h0000_FFFF << shamt;
        lane      = {16'd0, wdata[15:0]} << shamt;
      end
      default: begin
      end
    endcase
    merge_data = (word & ~mask) | (lane & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: issues word-aligned read/write strobes, stalls the pipeline
// until acknowledge or timeout, and performs read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              misaligned_o,
  output logic              err_o,
  load_store_unit_if.master mem
);

  lsu_state_e      state;
  logic [TO_W-1:0] wait_cnt;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic            req;
  logic            misaligned;
  logic            subword;
  logic            timed_out;
  logic [31:0]     load_data;
  logic [31:0]     merge_data;

  assign req        = MemRead_i | MemWrite_i;
  assign misaligned = is_misaligned(size_i, addr_i[1:0]);
  assign subword    = (size_i == SZ_BYTE) || (size_i == SZ_HALF);
  assign timed_out  = (wait_cnt == TO_W'(TIMEOUT - 1));
  assign stall_o    = req & (state != ST_DONE);

  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;
  assign mem.mem_read_o  = mem_read_q;
  assign mem.mem_write_o = mem_write_q;

  load_store_unit_align u_align (
    .word        (mem.mem_rdata_i),
    .offset      (addr_i[1:0]),
    .size        (size_i),
    .is_unsigned (unsigned_i),
    .wdata       (wdata_i),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // Access FSM; result flags are written only on entry to DONE so they self-clear after one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rdata_o      <= '0;
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
      rdata_o      <= '0;
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (req && misaligned) begin
            state        <= ST_DONE;
            done_o       <= 1'b1;
            misaligned_o <= 1'b1;
          end else if (req) begin
            mem_addr_q <= {addr_i[31:2], 2'b00};
            if (!MemWrite_i) begin
              state      <= ST_RD;
              mem_read_q <= 1'b1;
            end else if (subword) begin
              state      <= ST_RMW_RD;
              mem_read_q <= 1'b1;
            end else begin
              state       <= ST_WR;
              mem_write_q <= 1'b1;
              mem_wdata_q <= wdata_i;
            end
          end
        end
        ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR: begin
          if (mem.mem_ack_i && state == ST_RMW_RD) begin
            state       <= ST_RMW_WR;
            wait_cnt    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merge_data;
          end else if (mem.mem_ack_i || timed_out) begin
            // An ack in the last allowed cycle still completes normally.
            state       <= ST_DONE;
            wait_cnt    <= '0;
            done_o      <= 1'b1;
            err_o       <= ~mem.mem_ack_i;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (mem.mem_ack_i && state == ST_RD) rdata_o <= load_data;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural word memory answers the bus, and every
// completion and every memory write is matched against expectations queued at issue time.
module tb_load_store_unit;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        stall_o, done_o, misaligned_o, err_o;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .size_i       (size_i),
    .unsigned_i   (unsigned_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .misaligned_o (misaligned_o),
    .err_o        (err_o),
    .mem          (bus.master)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [31:0] wq[$];
  logic [31:0] ram [64];
  logic [31:0] exp_maddr = '0;
  logic        model_ack = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] model_rdata = '0;
  logic        prev_ack;
  bit          ack_en = 1'b1;
  int          ack_delay = 0;
  int          lat_m = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  exp_t        mon_e;

  assign bus.mem_ack_i   = model_ack | ack_force;
  assign bus.mem_rdata_i = model_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[8*off +: 16];
    if (sz == 2'd0) return uns ? {24'd0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return uns ? {16'd0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input int off,
                                            input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    if (sz == 2'd0)      w[8*off +: 8]  = wd[7:0];
    else if (sz == 2'd1) w[8*off +: 16] = wd[15:0];
    else                 w = wd;
    return w;
  endfunction

  // Memory model: acks after ack_delay wait cycles, checks address and write data on ack.
  always @(negedge clk_i) begin
    prev_ack  = model_ack;
    model_ack = 1'b0;
    if (prev_ack) lat_m = 0;
    if (rst_i || !(bus.mem_read_o || bus.mem_write_o)) begin
      lat_m = 0;
    end else begin
      if (bus.mem_read_o)  rd_cyc++;
      if (bus.mem_write_o) wr_cyc++;
      if (ack_en && lat_m >= ack_delay) begin
        model_ack = 1'b1;
        check("mem_addr", bus.mem_addr_o, exp_maddr);
        if (bus.mem_write_o) begin
          if (wq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
          else check("mem_wdata", bus.mem_wdata_o, wq.pop_front());
          ram[bus.mem_addr_o[7:2]] = bus.mem_wdata_o;
        end else begin
          model_rdata = ram[bus.mem_addr_o[7:2]];
        end
      end else begin
        lat_m++;
      end
    end
  end

  // Completion monitor.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rdata", rdata_o, mon_e.rdata);
        check("misaligned", 32'(misaligned_o), 32'(mon_e.mis));
        check("err", 32'(err_o), 32'(mon_e.err));
      end
    end
  end

  // Issue one request right after a negedge and follow it to completion.
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic exp_err,
                        input int exp_lat, input int exp_rdc, input int exp_wrc);
    int  lat, stalls, rd0, wr0;
    bit  seen;
    exp_maddr = {a[31:2], 2'b00};
    sb.push_back(exp_t'{exp_rd, exp_mis, exp_err});
    rd0 = rd_cyc;
    wr0 = wr_cyc;
    MemRead_i  = rd;
    MemWrite_i = wr;
    size_i     = sz;
    unsigned_i = uns;
    addr_i     = a;
    wdata_i    = wd;
    #1;
    lat    = 1;
    stalls = stall_o ? 1 : 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      lat++;
      if (done_o) seen = 1'b1;
      else if (stall_o) stalls++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
    check({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
    check({tag, "_rd_strobes"}, 32'(rd_cyc - rd0), 32'(exp_rdc));
    check({tag, "_wr_strobes"}, 32'(wr_cyc - wr0), 32'(exp_wrc));
    check({tag, "_strobe_drop"}, 32'({bus.mem_read_o, bus.mem_write_o}), 32'd0);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_writes_drained"}, 32'(wq.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_flags"}, 32'({stall_o, done_o, misaligned_o, err_o}), 32'd0);
    check({tag, "_strobes"}, 32'({bus.mem_read_o, bus.mem_write_o}), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d, off, idx;
    logic [1:0]  sz;
    logic        uns, is_st;
    logic [31:0] wd, old;
    bit          found;

    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    ram[4] = 32'hDEAD_BEEF;
    ram[8] = 32'h1122_3344;

    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases: word load, signed/unsigned sub-word loads.
    do_req("lw_10",  1, 0, 2'd2, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 0, 3, 1, 0);
    ram[4] = 32'h80FF_1234;
    do_req("lb_13",  1, 0, 2'd0, 0, 32'h13, 0, 32'hFFFF_FF80, 0, 0, 3, 1, 0);
    do_req("lbu_13", 1, 0, 2'd0, 1, 32'h13, 0, 32'h0000_0080, 0, 0, 3, 1, 0);
    do_req("lh_12",  1, 0, 2'd1, 0, 32'h12, 0, 32'hFFFF_80FF, 0, 0, 3, 1, 0);
    do_req("lhu_10", 1, 0, 2'd1, 1, 32'h10, 0, 32'h0000_1234, 0, 0, 3, 1, 0);
    do_req("lb_11",  1, 0, 2'd0, 0, 32'h11, 0, 32'h0000_0012, 0, 0, 3, 1, 0);
    do_req("lw_ill", 1, 0, 2'd3, 0, 32'h10, 0, 32'h80FF_1234, 0, 0, 3, 1, 0);

    // Sub-word stores via read-modify-write.
    wq.push_back(32'h1122_AB44);
    do_req("sb_21", 0, 1, 2'd0, 0, 32'h21, 32'h0000_00AB, 0, 0, 0, 4, 1, 1);
    do_req("lw_20", 1, 0, 2'd2, 0, 32'h20, 0, 32'h1122_AB44, 0, 0, 3, 1, 0);
    ack_delay = 2;
    wq.push_back(32'hBEEF_AB44);
    do_req("sh_22", 0, 1, 2'd1, 0, 32'h22, 32'h1234_BEEF, 0, 0, 0, 8, 3, 3);
    ack_delay = 0;

    // Misaligned accesses produce no strobe.
    do_req("lh_05",  1, 0, 2'd1, 0, 32'h05, 0, 0, 1, 0, 2, 0, 0);
    do_req("lw_12",  1, 0, 2'd2, 0, 32'h12, 0, 0, 1, 0, 2, 0, 0);
    do_req("ill_12", 1, 0, 2'd3, 0, 32'h12, 0, 0, 1, 0, 2, 0, 0);
    do_req("sw_31",  0, 1, 2'd2, 0, 32'h31, 32'h1, 0, 1, 0, 2, 0, 0);

    // Read and write together: the write wins.
    wq.push_back(32'hCAFE_F00D);
    do_req("rw_30", 1, 1, 2'd2, 0, 32'h30, 32'hCAFE_F00D, 0, 0, 0, 3, 0, 1);
    do_req("lw_30", 1, 0, 2'd2, 0, 32'h30, 0, 32'hCAFE_F00D, 0, 0, 3, 1, 0);

    // Timeout boundary: ack in the last allowed cycle versus one cycle too late.
    ack_delay = 15;
    do_req("lw_ack15", 1, 0, 2'd2, 0, 32'h20, 0, 32'hBEEF_AB44, 0, 0, 18, 16, 0);
    ack_delay = 16;
    do_req("lw_ack16", 1, 0, 2'd2, 0, 32'h20, 0, 0, 0, 1, 18, 16, 0);
    ack_delay = 0;
    ack_en = 1'b0;
    old = ram[12];
    do_req("sw_noack", 0, 1, 2'd2, 0, 32'h30, 32'h5555_AAAA, 0, 0, 1, 18, 0, 16);
    check("sw_noack_mem", ram[12], old);
    ack_en = 1'b1;

    // Random aligned traffic with random memory latency.
    for (int n = 0; n < 24; n++) begin
      d     = $urandom_range(0, 3);
      sz    = 2'($urandom_range(0, 2));
      uns   = 1'($urandom_range(0, 1));
      is_st = 1'($urandom_range(0, 1));
      idx   = $urandom_range(0, 63);
      off   = (sz == 2'd0) ? $urandom_range(0, 3) : (sz == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
      wd    = $urandom;
      ack_delay = d;
      old   = ram[idx];
      if (is_st) begin
        wq.push_back(ref_store(old, off, sz, wd));
        if (sz == 2'd2)
          do_req("rnd_sw", 0, 1, sz, uns, 32'(idx * 4 + off), wd, 0, 0, 0, d + 3, 0, d + 1);
        else
          do_req("rnd_ssub", 0, 1, sz, uns, 32'(idx * 4 + off), wd, 0, 0, 0, 2 * d + 4, d + 1, d + 1);
      end else begin
        do_req("rnd_ld", 1, 0, sz, uns, 32'(idx * 4 + off), wd,
               ref_load(old, off, sz, uns), 0, 0, d + 3, d + 1, 0);
      end
    end

    // Reset in RMW_WR while an ack is being presented: access is abandoned silently.
    ack_delay  = 3;
    old        = ram[9];
    exp_maddr  = 32'h24;
    MemWrite_i = 1'b1;
    size_i     = 2'd0;
    addr_i     = 32'h25;
    wdata_i    = 32'h5A;
    found      = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (bus.mem_write_o) found = 1'b1;
    end
    check("rst_reached_rmw_wr", 32'(found), 32'd1);
    rst_i      = 1'b1;
    ack_force  = 1'b1;
    MemWrite_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_all_zero("rst_mid");
    rst_i     = 1'b0;
    ack_force = 1'b0;
    repeat (4) @(negedge clk_i);
    check("rst_mem_untouched", ram[9], old);
    ack_delay = 0;
    do_req("lw_after_rst", 1, 0, 2'd2, 0, 32'h24, 0, old, 0, 0, 3, 1, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
